// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives active-low columns, debounces presses and
// releases on the synchronized active-low rows, and strobes the hex code of each accepted key.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DEBOUNCE_CNT = 250000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] keyboard,
  output logic [3:0] column,
  output logic [1:0] counter,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned DwellW = $clog2(SCAN_DIV);
  localparam int unsigned CntW   = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0]   CntLast   = CntW'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {StScan, StDebounce, StHeld} state_e;

  state_e            state_q, state_d;
  logic [3:0]        kb_meta_q, kb_sync_q;
  logic [DwellW-1:0] dwell_q, dwell_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        pattern_q, pattern_d;
  logic [3:0]        code_q, code_d;
  logic              valid_q, valid_d;
  logic              held_q, held_d;
  logic              sync_valid;
  logic [1:0]        row_idx;

  // A usable press is exactly one row pulled low.
  always_comb begin
    sync_valid = 1'b0;
    case (kb_sync_q)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: sync_valid = 1'b1;
      default:                            sync_valid = 1'b0;
    endcase
  end

  always_comb begin
    row_idx = 2'd0;
    case (pattern_q)
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    dwell_d   = dwell_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    pattern_d = pattern_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    held_d    = held_q;
    unique case (state_q)
      StScan: begin
        if (dwell_q == DwellLast) begin
          dwell_d = '0;
          if (sync_valid) begin
            pattern_d = kb_sync_q;
            cnt_d     = '0;
            state_d   = StDebounce;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + DwellW'(1);
        end
      end
      StDebounce: begin
        if (kb_sync_q == pattern_q) begin
          if (cnt_q == CntLast) begin
            state_d = StHeld;
            cnt_d   = '0;
            code_d  = {row_idx, 2'b00} + {2'b00, idx_q} + 4'd1;
            valid_d = 1'b1;
            held_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end else begin
          state_d = StScan;
          idx_d   = idx_q + 2'd1;
          dwell_d = '0;
        end
      end
      StHeld: begin
        // Column stays frozen, so other keys are invisible until release completes.
        if (kb_sync_q == 4'b1111) begin
          if (cnt_q == CntLast) begin
            state_d = StScan;
            held_d  = 1'b0;
            idx_d   = idx_q + 2'd1;
            dwell_d = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: state_d = StScan;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= StScan;
      kb_meta_q <= 4'b1111;
      kb_sync_q <= 4'b1111;
      dwell_q   <= '0;
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      pattern_q <= 4'b1111;
      code_q    <= 4'd0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      kb_meta_q <= keyboard;
      kb_sync_q <= kb_meta_q;
      dwell_q   <= dwell_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pattern_q <= pattern_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      held_q    <= held_d;
    end
  end

  assign column    = ~(4'b0001 << idx_q);
  assign counter   = idx_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule
